// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: waits for lock and delay-line ready, then releases
// NUM_DOM reset domains in order with programmable spacing; also owns the delay-tap load path.
module rst_sequencer #(
  parameter int                 NUM_DOM      = 3,
  parameter int                 CNT_W        = 16,
  parameter int                 HOLD_CYC     = 65535,
  parameter int                 STAGGER      = 16,
  parameter int                 SETTLE_CYC   = 32,
  parameter int                 TAP_W        = 5,
  parameter logic [NUM_DOM-1:0] TAP_RST_MASK = NUM_DOM'(2)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               locked,
  input  logic               dly_rdy,
  input  logic               soft_rst,
  input  logic [TAP_W-1:0]   tap_in,
  input  logic               tap_wr,
  output logic [TAP_W-1:0]   tap_val,
  output logic               tap_ld,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic               all_rdy,
  output logic [7:0]         lock_lost_cnt
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST   = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SETTLE  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_DOM-1:0] dom_reg, dom_next;
  logic               rdy_reg, rdy_next;
  logic [7:0]         lost_reg, lost_next;
  logic [TAP_W-1:0]   tap_val_reg;
  logic               tap_ld_reg;
  logic               lock_meta_reg, locked_s;
  logic [NUM_DOM-1:0] idx_onehot;

  // Decode of the domain currently waiting for its stagger slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOM; gi++) begin : g_idx_dec
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    dom_next   = dom_reg;
    lost_next  = lost_reg;

    // Lock loss outranks a software request; tap loading runs independently below.
    if (state_reg != ST_WAIT && !locked_s) begin
      state_next = ST_WAIT;
      cnt_next   = '0;
      idx_next   = '0;
      dom_next   = '1;
      if (lost_reg != 8'hFF) lost_next = lost_reg + 8'd1;
    end else if (state_reg != ST_WAIT && soft_rst) begin
      state_next = ST_HOLD;
      cnt_next   = '0;
      idx_next   = '0;
      dom_next   = '1;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          cnt_next = '0;
          dom_next = '1;
          if (locked_s && dly_rdy) state_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            dom_next[0] = 1'b0;
            cnt_next    = '0;
            idx_next    = IDX_W'(1);
            state_next  = (NUM_DOM == 1) ? ST_RUN : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cnt_reg == STAG_LAST) begin
            dom_next = dom_reg & ~idx_onehot;
            cnt_next = '0;
            idx_next = idx_reg + 1'b1;
            if (idx_reg == IDX_LAST) begin
              state_next = ST_RUN;
              idx_next   = '0;
            end
          end
        end
        ST_RUN: begin
          cnt_next = '0;
          if (tap_wr && TAP_RST_MASK != '0) begin
            dom_next   = dom_reg | TAP_RST_MASK;
            state_next = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tap_wr) begin
            cnt_next = '0;
          end else if (cnt_reg == SETTLE_LAST) begin
            dom_next   = dom_reg & ~TAP_RST_MASK;
            cnt_next   = '0;
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_WAIT;
          cnt_next   = '0;
          idx_next   = '0;
          dom_next   = '1;
        end
      endcase
    end

    // Ready only after a full cycle spent in RUN, so it trails the last release by one edge.
    rdy_next = (state_reg == ST_RUN) && (state_next == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_WAIT;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      dom_reg       <= '1;
      rdy_reg       <= 1'b0;
      lost_reg      <= '0;
      tap_val_reg   <= '0;
      tap_ld_reg    <= 1'b0;
      lock_meta_reg <= 1'b0;
      locked_s      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      dom_reg       <= dom_next;
      rdy_reg       <= rdy_next;
      lost_reg      <= lost_next;
      tap_val_reg   <= tap_wr ? tap_in : tap_val_reg;
      tap_ld_reg    <= tap_wr;
      lock_meta_reg <= locked;
      locked_s      <= lock_meta_reg;
    end
  end

  assign tap_val       = tap_val_reg;
  assign tap_ld        = tap_ld_reg;
  assign dom_rst       = dom_reg;
  assign all_rdy       = rdy_reg;
  assign lock_lost_cnt = lost_reg;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single-domain lock-driven reset counter.
- Holds NUM_DOM reset domains in reset until the clock generator is locked and the delay-line controller reports ready, then releases them in order with programmable spacing.
- Re-arms on lock loss or software request and counts lock-loss events.
- Owns the delay-tap load interface, so a tap change re-settles the selected domains.

Parameters:
- NUM_DOM, 3, number of reset domains (1..8); domain 0 is released first.
- CNT_W, 16, width of the internal hold/stagger/settle counter.
- HOLD_CYC, 65535, cycles held after lock+ready before domain 0 releases (1..2^CNT_W-1).
- STAGGER, 16, cycles between consecutive domain releases (1..2^CNT_W-1).
- SETTLE_CYC, 32, cycles the masked domains are re-held after a tap load in RUN (1..2^CNT_W-1).
- TAP_W, 5, delay-tap value width.
- TAP_RST_MASK, 3'b010, domains re-held after a tap load in RUN (NUM_DOM bits).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset; all state clears immediately on assertion.
- locked  in  1  clock-generator lock, asynchronous to clk; 2-flop synchronised internally to locked_s.
- dly_rdy  in  1  delay controller ready, synchronous to clk.
- soft_rst  in  1  single-cycle software reset request.
- tap_in  in  TAP_W  new delay-tap value.
- tap_wr  in  1  single-cycle tap write strobe.
- tap_val  out  TAP_W  registered tap value to the delay element.
- tap_ld  out  1  one-cycle load pulse, aligned with the new tap_val.
- dom_rst  out  NUM_DOM  active-high per-domain reset.
- all_rdy  out  1  high only in RUN.
- lock_lost_cnt  out  8  saturating lock-loss event counter.

Behaviour:
- While rstn=0, all outputs and state take their reset values:
  - dom_rst all 1, all_rdy 0, tap_val 0, tap_ld 0, lock_lost_cnt 0.
  - State WAIT, counter 0, domain index 0, synchroniser flops 0.
- States are WAIT, HOLD, RELEASE, RUN and SETTLE.
- WAIT:
  - dom_rst all 1.
  - When locked_s=1 and dly_rdy=1 in the same cycle, go to HOLD with cnt=0.
  - soft_rst is ignored in WAIT.
- HOLD:
  - cnt increments each cycle.
  - When cnt==HOLD_CYC-1, go to RELEASE, clear dom_rst[0] on that same edge, and set idx=1, cnt=0.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==STAGGER-1, clear dom_rst[idx], increment idx and reset cnt.
  - When the last domain clears, go to RUN. all_rdy goes to 1 one cycle after dom_rst[NUM_DOM-1] falls.
  - With NUM_DOM=1, go directly from HOLD to RUN; all_rdy rises one cycle after dom_rst[0] falls.
- RUN: hold state until one of the events below.
- Lock loss (locked_s=0 in any state other than WAIT):
  - Next edge: dom_rst all 1, all_rdy 0, go to WAIT.
  - lock_lost_cnt increments, saturating at 255.
  - Highest priority; a soft_rst or tap_wr in the same cycle is not acted on as a reset request.
- dly_rdy=0 outside WAIT has no effect.
- soft_rst in HOLD, RELEASE, RUN or SETTLE:
  - Next edge: dom_rst all 1, all_rdy 0, go to HOLD with cnt=0.
  - lock_lost_cnt is unchanged.
- Tap writes (tap_wr):
  - Accepted in every state, including during lock loss.
  - Next edge: tap_val<=tap_in and tap_ld=1 for exactly one cycle.
  - Back-to-back writes give back-to-back pulses; the last value wins.
- Tap write in RUN, with no lock loss or soft_rst that cycle:
  - Also set dom_rst |= TAP_RST_MASK, all_rdy=0, go to SETTLE with cnt=0.
- SETTLE:
  - When cnt==SETTLE_CYC-1, clear the masked dom_rst bits and return to RUN; all_rdy rises one cycle later.
  - A further tap_wr in SETTLE restarts cnt at 0.
- Tap writes in WAIT, HOLD or RELEASE do not change the sequence.
- If TAP_RST_MASK=0, a tap write in RUN only loads the tap; no state change, all_rdy stays 1.
- Counters never wrap: cnt clears on every state entry, and lock_lost_cnt saturates.

Test Plan:
- Release sequence. Params HOLD_CYC=8, STAGGER=4, NUM_DOM=3; rstn released; locked=1 and dly_rdy=1 from cycle 0.
  - dom_rst[0] falls 8 cycles after locked_s is seen, dom_rst[1] 4 cycles later, dom_rst[2] 4 cycles after that.
  - all_rdy rises 1 cycle after dom_rst[2] falls.
- Lock loss. Drop locked for 1 cycle mid-RELEASE.
  - All dom_rst return to 1 and all_rdy stays 0; lock_lost_cnt=1.
  - The full sequence repeats after relock.
  - Pulse locked low 300 times: lock_lost_cnt reads 255.
- Soft reset. soft_rst in RUN.
  - Next cycle dom_rst=3'b111 and all_rdy=0.
  - Release repeats with the HOLD+STAGGER timing; lock_lost_cnt is unchanged.
- Tap write in RUN. tap_in=5'd17 with tap_wr, mask 3'b010, SETTLE_CYC=6.
  - tap_val=17 with a 1-cycle tap_ld.
  - dom_rst=3'b010 for 6 cycles, then all_rdy=1 again.
  - A second tap_wr on SETTLE cycle 3 extends the hold to 6 cycles from that write.
- Tap write during HOLD. tap_val and tap_ld update; release timing is identical to the first scenario.
- Simultaneous events. locked drop, soft_rst and tap_wr in the same cycle in RUN.
  - Result: state WAIT, lock_lost_cnt+1, tap_ld pulses; no SETTLE entry.
  - rstn asserted mid-RELEASE: all outputs reach their reset values without a clock edge.
